// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store controller for a single-port synchronous data memory
//
// Purpose: accepts one word or byte load/store at a time over a valid/ready
// handshake, drives the memory pins, captures one-cycle-latency read data and
// returns a response strobe per request. Byte stores are read-modify-write.
// Word addresses >= DEPTH are rejected without touching memory.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_req_valid         request present
//   o_req_ready         request accepted this cycle (IDLE only)
//   i_req_we            1 = store, 0 = load
//   i_req_byte          1 = byte op, 0 = word op
//   i_req_addr          byte address; [ADDR_W:1] word, [0] lane
//   i_req_wdata         store data (byte stores use [7:0])
//   o_resp_valid        one-cycle response strobe
//   o_resp_err          illegal address qualifier
//   o_resp_rdata        load data, zero for stores and errors
//   o_mem_addr          memory word address
//   o_mem_we            memory write enable
//   o_mem_wd            memory write data
//   i_mem_rd            memory read data (one cycle after address)
module mem_access_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic              i_req_byte,
  input  logic [ADDR_W:0]   i_req_addr,
  input  logic [15:0]       i_req_wdata,
  output logic              o_resp_valid,
  output logic              o_resp_err,
  output logic [15:0]       o_resp_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [15:0]       o_mem_wd,
  input  logic [15:0]       i_mem_rd
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t              r_state;
  state_t              w_next;
  logic                r_we;
  logic                r_byte;
  logic [ADDR_W:0]     r_addr;
  logic [15:0]         r_wdata;
  logic [15:0]         r_merged;
  logic [ADDR_W-1:0]   r_last_addr;
  logic                w_mem_we;
  logic                w_accept;
  logic                w_illegal;
  logic [ADDR_W-1:0]   w_word;
  logic [7:0]          w_rd_byte;

  assign w_word    = r_addr[ADDR_W:1];
  assign w_accept  = (r_state == ST_IDLE) && i_req_valid;
  assign w_illegal = {1'b0, i_req_addr[ADDR_W:1]} >= LP_DEPTH;
  assign w_rd_byte = r_addr[0] ? i_mem_rd[15:8] : i_mem_rd[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_byte      <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_merged    <= '0;
      r_last_addr <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= i_req_we;
        r_byte  <= i_req_byte;
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
      end
      // Merge the new byte into the word just read; only used by byte stores.
      if (r_state == ST_WAIT) begin
        r_merged <= r_addr[0] ? {r_wdata[7:0], i_mem_rd[7:0]}
                              : {i_mem_rd[15:8], r_wdata[7:0]};
      end
      // Memory address holds its last driven value outside READ/WRITE.
      if (r_state == ST_READ || r_state == ST_WRITE) begin
        r_last_addr <= w_word;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    o_resp_err   = 1'b0;
    o_resp_rdata = 16'h0000;
    o_mem_addr   = r_last_addr;
    w_mem_we     = 1'b0;
    o_mem_wd     = 16'h0000;
    case (r_state)
      ST_IDLE: begin
        o_req_ready = ~rst;
        if (i_req_valid) begin
          if (w_illegal)                   w_next = ST_ERR;
          else if (i_req_we && !i_req_byte) w_next = ST_WRITE;
          else                              w_next = ST_READ;
        end
      end
      ST_READ: begin
        o_mem_addr = w_word;
        w_next     = ST_WAIT;
      end
      ST_WAIT: begin
        if (!r_we) begin
          o_resp_valid = 1'b1;
          o_resp_rdata = r_byte ? {8'h00, w_rd_byte} : i_mem_rd;
          w_next       = ST_IDLE;
        end else begin
          w_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        o_mem_addr   = w_word;
        w_mem_we     = 1'b1;
        o_mem_wd     = r_byte ? r_merged : r_wdata;
        o_resp_valid = 1'b1;
        w_next       = ST_IDLE;
      end
      ST_ERR: begin
        o_resp_valid = 1'b1;
        o_resp_err   = 1'b1;
        w_next       = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Reset must suppress a write even if it lands in the WRITE cycle.
  assign o_mem_we = w_mem_we & ~rst;

endmodule
